// File: rtl/mole_hit_detect_pkg.sv
// Shared types and constants for the whack-a-mole hit detector.
package mole_hit_detect_pkg;

    localparam int NUM_HOLES = 18;
    localparam int LFSR_W    = 5;
    localparam int TIMER_W   = 26;

    // Feedback taps for x^5 + x^3 + 1 (bits 4 and 2 of a left-shifting register)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_ACTIVE,
        ST_COOLDOWN
    } state_t;

    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [LFSR_W-1:0] v);
        logic [LFSR_W-1:0] idx;
        idx = (v < LFSR_W'(NUM_HOLES)) ? v : v - LFSR_W'(NUM_HOLES);
        return {{(NUM_HOLES-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mole_hit_detect_sw_sync_edge.sv
// Two-flop synchronizer plus history flop per switch; toggle flags either edge.
module sw_sync_edge #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_async,
    output logic [WIDTH-1:0] toggle
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            meta_q <= sw_async;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign toggle = sync_q ^ hist_q;

endmodule

// File: rtl/mole_hit_detect.sv
// Target sequencing, hit/miss/wrong detection and pseudo-random hole selection.
//
// state     | meaning
// IDLE      | no game running, all outputs dark
// SPAWN     | one cycle: pick hole from LFSR, arm the lit timer
// ACTIVE    | target lit, waiting for hit or timeout
// COOLDOWN  | dark gap between targets, toggles ignored
module mole_hit_detect
    import mole_hit_detect_pkg::*;
#(
    parameter int unsigned       MOLE_TICKS     = 50_000_000,
    parameter int unsigned       COOLDOWN_TICKS = 12_500_000,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 5'h1F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_pulse,
    input  logic                 game_active,
    input  logic [NUM_HOLES-1:0] sw,
    output logic [NUM_HOLES-1:0] led_target,
    output logic [NUM_HOLES-1:0] hit_pulse,
    output logic                 miss_pulse,
    output logic                 wrong_pulse
);

    localparam logic [TIMER_W-1:0] MOLE_LOAD = TIMER_W'(MOLE_TICKS - 1);
    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOLDOWN_TICKS - 1);

    logic [NUM_HOLES-1:0] toggle;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
    logic [NUM_HOLES-1:0] led_q, led_d;
    logic [NUM_HOLES-1:0] hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic                 wrong_q, wrong_d;
    logic                 tgt_tog;
    logic                 other_tog;

    sw_sync_edge #(
        .WIDTH (NUM_HOLES)
    ) u_sw_sync_edge (
        .clk      (clk),
        .rst      (rst),
        .sw_async (sw),
        .toggle   (toggle)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        led_d     = led_q;
        hit_d     = '0;
        miss_d    = 1'b0;
        wrong_d   = 1'b0;
        lfsr_d    = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        tgt_tog   = |(toggle & led_q);
        other_tog = |(toggle & ~led_q);

        if (!game_active) begin
            state_d = ST_IDLE;
            timer_d = '0;
            led_d   = '0;
        end else if (start_pulse) begin
            // restart wins over any hit, miss or wrong in flight
            state_d = ST_SPAWN;
            led_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SPAWN: begin
                    led_d   = hole_onehot(lfsr_q);
                    timer_d = MOLE_LOAD;
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    wrong_d = other_tog;
                    if (tgt_tog) begin
                        hit_d   = led_q;
                        led_d   = '0;
                        timer_d = COOL_LOAD;
                        state_d = ST_COOLDOWN;
                    end else if (timer_q == '0) begin
                        miss_d  = 1'b1;
                        led_d   = '0;
                        timer_d = COOL_LOAD;
                        state_d = ST_COOLDOWN;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                ST_COOLDOWN: begin
                    // leave as the count reaches zero so the gap, SPAWN included, is COOLDOWN_TICKS
                    if (timer_q <= TIMER_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_SPAWN;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            lfsr_q  <= LFSR_SEED;
            led_q   <= '0;
            hit_q   <= '0;
            miss_q  <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            lfsr_q  <= lfsr_d;
            led_q   <= led_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wrong_q <= wrong_d;
        end
    end

    assign led_target  = led_q;
    assign hit_pulse   = hit_q;
    assign miss_pulse  = miss_q;
    assign wrong_pulse = wrong_q;

endmodule

// File: tb/tb_mole_hit_detect.sv
// Scoreboard bench for mole_hit_detect: game-rule reference model feeds an
// expected-pulse queue, a monitor pops it whenever the DUT pulses.
module tb_mole_hit_detect;

    localparam int       MT   = 8;
    localparam int       CT   = 4;
    localparam int       SEED = 31;

    typedef struct {
        int          cyc;
        logic [17:0] hit;
        bit          miss;
        bit          wrong;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_pulse = 1'b0;
    logic        game_active = 1'b0;
    logic [17:0] sw = '0;
    logic [17:0] led_target;
    logic [17:0] hit_pulse;
    logic        miss_pulse;
    logic        wrong_pulse;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t mon_e;
    bit   started = 0;
    int   mon_cyc = 0;
    int   hit_cnt = 0, miss_cnt = 0, wrong_cnt = 0;
    logic [17:0] prev_led = '0;

    // reference model state, in game terms
    int          m_cyc   = 0;
    int          m_lfsr  = SEED;
    int          m_phase = 0;   // 0 no game, 1 choosing, 2 lit, 3 dark gap
    int          m_left  = 0;   // cycles left in the current lit/dark phase
    logic [17:0] m_led   = '0;
    logic [17:0] smp1 = '0, smp2 = '0, smp3 = '0;  // sw as seen 1, 2, 3 edges ago

    logic [17:0] sw_v = '0;

    mole_hit_detect #(
        .MOLE_TICKS     (MT),
        .COOLDOWN_TICKS (CT),
        .LFSR_SEED      (5'h1F)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_pulse (start_pulse),
        .game_active (game_active),
        .sw          (sw),
        .led_target  (led_target),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
        .wrong_pulse (wrong_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int hole(input int v);
        return (v < 18) ? v : v - 18;
    endfunction

    function automatic int idx_of(input logic [17:0] v);
        for (int i = 0; i < 18; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Predicts the outcome of the next rising edge from the inputs about to be applied.
    task automatic model_step(input bit r, input bit st, input bit ga, input logic [17:0] s);
        logic [17:0] tog;
        exp_t        e;
        m_cyc++;
        tog = smp2 ^ smp3;
        if (r) begin
            m_lfsr = SEED; m_phase = 0; m_left = 0; m_led = '0;
            smp1 = '0; smp2 = '0; smp3 = '0;
            return;
        end
        e.cyc = m_cyc; e.hit = '0; e.miss = 0; e.wrong = 0;
        if (!ga) begin
            m_phase = 0; m_left = 0; m_led = '0;
        end else if (st) begin
            m_phase = 1; m_led = '0;
        end else if (m_phase == 1) begin
            m_led  = 18'(1) << hole(m_lfsr);
            m_left = MT;
            m_phase = 2;
        end else if (m_phase == 2) begin
            e.wrong = |(tog & ~m_led);
            if (|(tog & m_led)) begin
                e.hit = m_led; m_led = '0; m_left = CT - 1; m_phase = 3;
            end else if (m_left == 1) begin
                e.miss = 1; m_led = '0; m_left = CT - 1; m_phase = 3;
            end else begin
                m_left--;
            end
        end else if (m_phase == 3) begin
            m_left--;
            if (m_left <= 0) m_phase = 1;
        end
        m_lfsr = ((m_lfsr << 1) & 31) | (((m_lfsr >> 4) ^ (m_lfsr >> 2)) & 1);
        smp3 = smp2; smp2 = smp1; smp1 = s;
        if (|e.hit || e.miss || e.wrong) sb.push_back(e);
    endtask

    // One clock: drive at the falling edge, model the rising edge, return just after it.
    task automatic tick(input bit r, input bit st, input bit ga, input logic [17:0] s);
        @(negedge clk);
        rst = r; start_pulse = st; game_active = ga; sw = s;
        model_step(r, st, ga, s);
        started = 1;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 1, sw_v);
    endtask

    task automatic wait_lit(input string name);
        int n = 0;
        while (led_target == '0 && n < 64) begin
            tick(0, 0, 1, sw_v);
            n++;
        end
        chk(name, 32'(led_target != '0), 32'd1);
    endtask

    task automatic run_len(input bit lit, output int n);
        n = 0;
        while (((led_target != '0) == lit) && n < 100) begin
            n++;
            tick(0, 0, 1, sw_v);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (started) begin
            mon_cyc++;
            chk("led_target", 32'(led_target), 32'(m_led));
            chk("led_onehot", 32'($countones(led_target) <= 1), 32'd1);
            while (sb.size() > 0 && sb[0].cyc < mon_cyc) begin
                mon_e = sb.pop_front();
                checks++; failures++;
                $display("FAIL pulse_missing cyc=%0d actual=none required hit=%h miss=%b wrong=%b",
                         mon_e.cyc, mon_e.hit, mon_e.miss, mon_e.wrong);
            end
            if (|hit_pulse || miss_pulse || wrong_pulse) begin
                if (sb.size() == 0 || sb[0].cyc != mon_cyc) begin
                    checks++; failures++;
                    $display("FAIL pulse_unexpected cyc=%0d actual hit=%h miss=%b wrong=%b required=none",
                             mon_cyc, hit_pulse, miss_pulse, wrong_pulse);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_hit", 32'(hit_pulse), 32'(mon_e.hit));
                    chk("sb_miss", 32'(miss_pulse), 32'(mon_e.miss));
                    chk("sb_wrong", 32'(wrong_pulse), 32'(mon_e.wrong));
                end
            end
            if (|hit_pulse)
                chk("hit_subset_prev_led",
                    32'(((hit_pulse & ~prev_led) == '0) && ($countones(hit_pulse) == 1)), 32'd1);
            hit_cnt   += (|hit_pulse) ? 1 : 0;
            miss_cnt  += miss_pulse ? 1 : 0;
            wrong_cnt += wrong_pulse ? 1 : 0;
            prev_led = led_target;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, h0, m0, w0;
        bit ga_v;

        // reset with a switch already high: its post-reset toggle lands in IDLE
        sw_v = 18'h1;
        for (int i = 0; i < 3; i++) tick(1, 0, 0, sw_v);
        idle(5);
        chk("reset_led", 32'(led_target), 32'd0);
        chk("reset_pulses", 32'(hit_cnt + miss_cnt + wrong_cnt), 32'd0);

        // hit
        tick(0, 1, 1, sw_v);
        wait_lit("hit_lit");
        k = idx_of(m_led);
        sw_v[k] = ~sw_v[k];
        idle(3);
        chk("hit_latency", 32'(hit_pulse), 32'(18'(1) << k));
        chk("hit_led_clear", 32'(led_target), 32'd0);
        tick(0, 0, 1, sw_v);
        chk("hit_one_cycle", 32'(hit_pulse), 32'd0);
        run_len(0, n);
        chk("hit_dark_cycles", 32'(n + 1), 32'(CT));

        // timeout
        h0 = hit_cnt; m0 = miss_cnt;
        run_len(1, n);
        chk("timeout_lit_cycles", 32'(n), 32'(MT));
        chk("timeout_miss_once", 32'(miss_cnt - m0), 32'd1);
        run_len(0, n);
        chk("timeout_dark_cycles", 32'(n), 32'(CT));
        chk("timeout_no_hit", 32'(hit_cnt - h0), 32'd0);

        // wrong, then target + neighbour together
        k = idx_of(m_led);
        sw_v[(k+1)%18] = ~sw_v[(k+1)%18];
        idle(3);
        chk("wrong_pulse", 32'(wrong_pulse), 32'd1);
        chk("wrong_target_kept", 32'(led_target), 32'(18'(1) << k));
        sw_v[k] = ~sw_v[k];
        sw_v[(k+1)%18] = ~sw_v[(k+1)%18];
        idle(3);
        chk("both_hit", 32'(hit_pulse), 32'(18'(1) << k));
        chk("both_wrong", 32'(wrong_pulse), 32'd1);

        // toggle reaches the FSM on the timer==0 cycle
        run_len(0, n);
        k = idx_of(m_led);
        m0 = miss_cnt; h0 = hit_cnt;
        idle(5);
        sw_v[k] = ~sw_v[k];
        idle(3);
        chk("boundary_hit", 32'(hit_pulse), 32'(18'(1) << k));
        chk("boundary_no_miss", 32'(miss_cnt - m0), 32'd0);
        chk("boundary_hit_count", 32'(hit_cnt - h0), 32'd1);

        // abort via game_active, then via rst
        run_len(0, n);
        idle(2);
        h0 = hit_cnt; m0 = miss_cnt; w0 = wrong_cnt;
        tick(0, 0, 0, sw_v);
        chk("abort_led", 32'(led_target), 32'd0);
        idle(3);
        chk("abort_stays_idle", 32'(led_target), 32'd0);
        chk("abort_no_pulses", 32'(hit_cnt + miss_cnt + wrong_cnt - h0 - m0 - w0), 32'd0);
        tick(0, 1, 1, sw_v);
        wait_lit("restart_lit");
        idle(2);
        tick(1, 0, 1, sw_v);
        chk("rst_outputs", 32'({led_target, hit_pulse, miss_pulse, wrong_pulse} != '0), 32'd0);
        tick(0, 1, 1, sw_v);
        wait_lit("post_rst_lit");

        // random play
        ga_v = 1;
        for (int i = 0; i < 10000; i++) begin
            bit r, st;
            r  = ($urandom_range(0, 2999) == 0);
            st = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 499) == 0) ga_v = 0;
            else if (!ga_v && $urandom_range(0, 9) == 0) ga_v = 1;
            if ($urandom_range(0, 7) == 0) sw_v ^= 18'(1) << $urandom_range(0, 17);
            if (m_led != '0 && $urandom_range(0, 11) == 0) sw_v ^= m_led;
            if (!ga_v && $urandom_range(0, 3) == 0) st = 1;
            tick(r, st, ga_v, sw_v);
        end
        for (int i = 0; i < 5; i++) tick(0, 0, 0, sw_v);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("random_saw_hits", 32'(hit_cnt > 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
